vga_timing_compositor: RTL

//  Raster source for the 800x600 VGA display; the other end of the sprite pixel interface.

---
 rtl/vga_timing_compositor_if.sv | 27 ++
 rtl/vga_timing_compositor.sv | 89 ++++++++
 2 files changed

// File: rtl/vga_timing_compositor_if.sv
// Pixel-side bundle between the raster compositor and the sprite widgets.
// The master drives the scan position, sync and colour pins; the slave (widgets/pins) returns hit flags and colours.
interface vga_timing_compositor_if;
  logic        layer0_yes;
  logic [11:0] layer0_rgb;
  logic        layer1_yes;
  logic [11:0] layer1_rgb;
  logic [11:0] bg_rgb;
  logic [10:0] X;
  logic [10:0] Y;
  logic        frame_tick;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  modport master (
    input  layer0_yes, layer0_rgb, layer1_yes, layer1_rgb, bg_rgb,
    output X, Y, frame_tick, hsync, vsync, red, green, blue
  );

  modport slave (
    output layer0_yes, layer0_rgb, layer1_yes, layer1_rgb, bg_rgb,
    input  X, Y, frame_tick, hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_compositor.sv
// VGA raster generator and two-layer compositor: scan counters, sync windows,
// per-frame movement tick and a registered colour/sync output stage.
module vga_timing_compositor #(
  parameter int H_VIS    = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_VIS    = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  vga_timing_compositor_if.master  vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_C  = 11'(V_VIS);
  localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active, hs_raw, vs_raw;

  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
    end
  end

  // Widget hit/colour are combinational from X,Y, so the pixel is chosen in the
  // same cycle and registered together with sync to keep them aligned.
  always_comb begin
    active = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hs_raw = (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
    vs_raw = (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
    rgb_d  = 12'h000;
    if (active) begin
      if (vga.layer0_yes)      rgb_d = vga.layer0_rgb;
      else if (vga.layer1_yes) rgb_d = vga.layer1_rgb;
      else                     rgb_d = vga.bg_rgb;
    end
    hsync_d = hs_raw ? SYNC_POL : !SYNC_POL;
    vsync_d = vs_raw ? SYNC_POL : !SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      rgb_q   <= '0;
      hsync_q <= !SYNC_POL;
      vsync_q <= !SYNC_POL;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  // Tick lands at the start of vertical blank so widgets move outside the visible area.
  assign vga.frame_tick = (hcnt_q == 11'd0) && (vcnt_q == V_VIS_C);
  assign vga.X          = hcnt_q;
  assign vga.Y          = vcnt_q;
  assign vga.red        = rgb_q[11:8];
  assign vga.green      = rgb_q[7:4];
  assign vga.blue       = rgb_q[3:0];
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;

endmodule
